// File: rtl/pair_reduce_engine.sv
// Loads DEPTH_A samples into buffer A, reduces each adjacent pair through a selectable ALU into buffer B.
// Optional PAIR_REDUCE_SAT_EN: add/sub saturate instead of wrapping.
module pair_reduce_engine #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_A = 8,
    parameter int AW_B    = $clog2(DEPTH_A / 2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op_sel,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             busy,
    output logic             done,
    input  logic [AW_B-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW_A    = $clog2(DEPTH_A);
    localparam int DEPTH_B = DEPTH_A / 2;
    localparam logic [AW_A:0]   PROC_LAST = (AW_A + 1)'(DEPTH_A);
    localparam logic [AW_A-1:0] WR_LAST   = AW_A'(DEPTH_A - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PROC, DONE} stateT;

    stateT            stateQ;
    stateT            stateNext;
    logic [1:0]       opSel;
    logic [AW_A-1:0]  wrPtr;
    logic [AW_A:0]    procCnt;
    logic [WIDTH-1:0] bufA [DEPTH_A];
    logic [WIDTH-1:0] bufB [DEPTH_B];

    logic [WIDTH-1:0] aRdData_p1;
    logic [AW_A-1:0]  idx_p1;
    logic             vld_p1;
    logic [WIDTH-1:0] dly_p2;
    logic             wrEnB;
    logic [WIDTH-1:0] result;

    function automatic logic [WIDTH-1:0] satAdd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef PAIR_REDUCE_SAT_EN
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WIDTH] ? '1 : s[WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] satSub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef PAIR_REDUCE_SAT_EN
        return (b > a) ? '0 : a - b;
`else
        return a - b;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] aluOp(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   return satAdd(a, b);
            2'b01:   return satSub(a, b);
            2'b10:   return (a > b) ? a : b;
            default: return (a < b) ? a : b;
        endcase
    endfunction

    always_comb begin
        stateNext = stateQ;
        case (stateQ)
            IDLE, DONE: if (start) stateNext = LOAD;
            LOAD:       if (din_valid && wrPtr == WR_LAST) stateNext = PROC;
            PROC:       if (procCnt == PROC_LAST) stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    assign din_ready = (stateQ == LOAD);
    assign busy      = (stateQ == LOAD) || (stateQ == PROC);
    assign done      = (stateQ == DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ  <= IDLE;
            opSel   <= 2'b00;
            wrPtr   <= '0;
            procCnt <= '0;
            vld_p1  <= 1'b0;
            idx_p1  <= '0;
            dly_p2  <= '0;
        end else begin
            stateQ <= stateNext;
            if ((stateQ == IDLE || stateQ == DONE) && start)
                opSel <= op_sel;
            if (stateQ == LOAD && din_valid)
                wrPtr <= wrPtr + 1'b1;
            procCnt <= (stateQ == PROC) ? procCnt + 1'b1 : '0;
            // stage p1: A read returns the sample issued last cycle
            vld_p1  <= (stateQ == PROC) && (procCnt < PROC_LAST);
            idx_p1  <= procCnt[AW_A-1:0];
            // stage p2: the even sample waits here for its odd partner
            if (vld_p1)
                dly_p2 <= aRdData_p1;
        end
    end

    // Buffer A holds no reset; its contents are only meaningful after a full load.
    always_ff @(posedge clock) begin
        if (stateQ == LOAD && din_valid)
            bufA[wrPtr] <= din;
        aRdData_p1 <= bufA[procCnt[AW_A-1:0]];
    end

    assign wrEnB  = vld_p1 && idx_p1[0];
    assign result = aluOp(opSel, dly_p2, aRdData_p1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_B; i++)
                bufB[i] <= '0;
            rd_data <= '0;
        end else begin
            if (wrEnB)
                bufB[idx_p1[AW_A-1:1]] <= result;
            rd_data <= bufB[rd_addr];
        end
    end

endmodule

// File: tb/tb_pair_reduce_engine.sv
// Randomised self-checking bench for pair_reduce_engine against a pairwise-reduction reference model.
module tb_pair_reduce_engine;

    localparam int WIDTH   = 8;
    localparam int DEPTH_A = 8;
    localparam int AW_B    = 2;
    localparam int NB      = DEPTH_A / 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             busy;
    logic             done;
    logic [AW_B-1:0]  rd_addr;
    logic [WIDTH-1:0] rd_data;

    int tests  = 0;
    int failed = 0;
    int expB[NB];
    int smp[DEPTH_A];

    always #5 clock = ~clock;

    pair_reduce_engine #(.WIDTH(WIDTH), .DEPTH_A(DEPTH_A)) dut (
        .clock(clock), .reset(reset), .start(start), .op_sel(op_sel),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    function automatic int refOp(input int op, input int a, input int b);
        int maxv;
        int r;
        maxv = (1 << WIDTH) - 1;
        case (op)
            0: begin
                r = a + b;
`ifdef PAIR_REDUCE_SAT_EN
                if (r > maxv) r = maxv;
`else
                r = r % (maxv + 1);
`endif
            end
            1: begin
                r = a - b;
`ifdef PAIR_REDUCE_SAT_EN
                if (r < 0) r = 0;
`else
                if (r < 0) r = r + maxv + 1;
`endif
            end
            2:       r = (a > b) ? a : b;
            default: r = (a < b) ? a : b;
        endcase
        return r;
    endfunction

    task automatic modelExpect(input int op);
        for (int k = 0; k < NB; k++)
            expB[k] = refOp(op, smp[2*k], smp[2*k+1]);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic readCheck(input string nm);
        for (int k = 0; k < NB; k++) begin
            rd_addr = AW_B'(k);
            tick();
            tests++;
            if (rd_data !== WIDTH'(expB[k])) begin
                failed++;
                $display("FAIL %s B[%0d]: got %0d expected %0d", nm, k, rd_data, expB[k]);
            end
        end
    endtask

    // One full run: start, load smp[], wait for done, checking handshake and PROC length.
    task automatic runPass(input int op, input bit toggle, input bit noise, input string nm);
        int  acc;
        int  cyc;
        bit  busyBad;
        start  = 1'b1;
        op_sel = op[1:0];
        tick();
        start  = 1'b0;
        op_sel = ~op[1:0];
        tests++;
        if ({din_ready, busy, done} !== 3'b110) begin
            failed++;
            $display("FAIL %s load_entry: rdy/busy/done=%b expected 110", nm, {din_ready, busy, done});
        end
        acc = 0;
        cyc = 0;
        while (acc < DEPTH_A && cyc < 200) begin
            din       = WIDTH'(smp[acc]);
            din_valid = toggle ? ~cyc[0] : 1'b1;
            if (noise) start = 1'($urandom % 2);
            tick();
            if (din_valid) acc++;
            cyc++;
        end
        din_valid = 1'b0;
        tests++;
        if (acc != DEPTH_A) begin
            failed++;
            $display("FAIL %s load_timeout: accepted %0d expected %0d", nm, acc, DEPTH_A);
        end
        cyc     = 0;
        busyBad = 1'b0;
        while (!done && cyc < 50) begin
            if (!busy || din_ready) busyBad = 1'b1;
            if (noise) start = 1'($urandom % 2);
            tick();
            cyc++;
        end
        start = 1'b0;
        tests++;
        if (cyc != DEPTH_A + 1) begin
            failed++;
            $display("FAIL %s proc_len: got %0d cycles expected %0d", nm, cyc, DEPTH_A + 1);
        end
        tests++;
        if (busyBad || busy !== 1'b0 || din_ready !== 1'b0) begin
            failed++;
            $display("FAIL %s proc_flags: busyBad=%0b busy=%0b rdy=%0b expected 0 0 0", nm, busyBad, busy, din_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op_sel = 2'b00; din = '0; din_valid = 1'b0; rd_addr = '0;
        tick();
        tick();
        tests++;
        if ({din_ready, busy, done} !== 3'b000 || rd_data !== '0) begin
            failed++;
            $display("FAIL reset_outputs: rdy/busy/done=%b rd_data=%0d expected 000 0", {din_ready, busy, done}, rd_data);
        end
        reset = 1'b1;
        tick();
        for (int k = 0; k < NB; k++) expB[k] = 0;
        readCheck("reset_clear");
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_idle_hold: busy=%0b done=%0b expected 0 0", busy, done);
        end
    endtask

    task automatic test_add_basic();
        for (int i = 0; i < DEPTH_A; i++) smp[i] = i + 1;
        runPass(0, 1'b0, 1'b0, "add_basic");
        expB[0] = 3; expB[1] = 7; expB[2] = 11; expB[3] = 15;
        readCheck("add_basic");
    endtask

    task automatic test_sub();
        smp[0] = 10; smp[1] = 3; smp[2] = 3; smp[3] = 10;
        smp[4] = 0;  smp[5] = 0; smp[6] = 255; smp[7] = 1;
        runPass(1, 1'b0, 1'b0, "sub");
        modelExpect(1);
        readCheck("sub");
    endtask

    task automatic test_add_wrap();
        smp[0] = 200; smp[1] = 100; smp[2] = 255; smp[3] = 255;
        smp[4] = 128; smp[5] = 127; smp[6] = 0;   smp[7] = 0;
        runPass(0, 1'b0, 1'b0, "add_wrap");
        modelExpect(0);
        readCheck("add_wrap");
    endtask

    task automatic test_maxmin();
        smp[0] = 5; smp[1] = 9;   smp[2] = 9; smp[3] = 5;
        smp[4] = 0; smp[5] = 255; smp[6] = 7; smp[7] = 7;
        runPass(2, 1'b0, 1'b0, "max");
        modelExpect(2);
        readCheck("max");
        readCheck("max_held");
        runPass(3, 1'b0, 1'b0, "min");
        modelExpect(3);
        readCheck("min");
    endtask

    task automatic test_stall_noise();
        for (int i = 0; i < DEPTH_A; i++) smp[i] = i + 1;
        runPass(0, 1'b1, 1'b1, "stall_noise");
        modelExpect(0);
        readCheck("stall_noise");
    endtask

    task automatic test_abort();
        rd_addr   = AW_B'(1);
        start     = 1'b1;
        op_sel    = 2'b00;
        tick();
        start     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din       = WIDTH'($urandom);
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        reset     = 1'b0;
        #1;
        tests++;
        if ({din_ready, busy, done} !== 3'b000 || rd_data !== '0) begin
            failed++;
            $display("FAIL abort_async: rdy/busy/done=%b rd_data=%0d expected 000 0", {din_ready, busy, done}, rd_data);
        end
        tick();
        reset = 1'b1;
        tick();
        for (int k = 0; k < NB; k++) expB[k] = 0;
        readCheck("abort_clear");
        for (int i = 0; i < DEPTH_A; i++) smp[i] = int'($urandom % 256);
        runPass(1, 1'b0, 1'b0, "after_abort");
        modelExpect(1);
        readCheck("after_abort");
    endtask

    task automatic test_random();
        int op;
        for (int r = 0; r < 8; r++) begin
            op = int'($urandom % 4);
            for (int i = 0; i < DEPTH_A; i++) smp[i] = int'($urandom % 256);
            runPass(op, 1'($urandom % 2), 1'($urandom % 2), "random");
            modelExpect(op);
            readCheck("random");
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_sub();
        test_add_wrap();
        test_maxmin();
        test_stall_noise();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pair_reduce_engine.md
Name: pair_reduce_engine

Overview:
- Parametrised successor of the two-buffer sequential datapath.
- Loads DEPTH_A samples into buffer A under a valid/ready handshake. Then streams them through a one-sample delay and a selectable ALU, reducing each adjacent pair to one result stored in buffer B.
- Results are read back through a registered read port. Sits between a sample source and a downstream consumer polling `done`.

Parameters:
- WIDTH, 8, sample and result width in bits.
- DEPTH_A, 8, buffer A depth. Power of two, ≥4. Buffer B depth = DEPTH_A/2.
- AW_B, $clog2(DEPTH_A/2), buffer B address width (derived; do not override).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a new load/process run; honoured in IDLE or DONE only.
- op_sel  input  2  00 add, 01 subtract, 10 max, 11 min. Sampled on accepted start.
- din  input  WIDTH  sample data.
- din_valid  input  1  sample present.
- din_ready  output  1  high only in LOAD.
- busy  output  1  high in LOAD or PROC.
- done  output  1  high in DONE.
- rd_addr  input  AW_B  buffer B read address.
- rd_data  output  WIDTH  registered buffer B data.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; all counters and the delay register are 0.
  - din_ready=0, busy=0, done=0, rd_data=0.
  - Buffer B is cleared to 0; buffer A contents are undefined.
  - Reset asserted mid-LOAD or mid-PROC aborts the run immediately.
- FSM states: IDLE, LOAD, PROC, DONE.
  - IDLE→LOAD on start=1; op_sel is latched.
  - DONE→LOAD on start=1; op_sel is re-latched and the buffer B contents are retained until overwritten.
  - start is ignored in LOAD and PROC.
- LOAD:
  - Each cycle with din_valid=1 (din_ready=1), write din to A[wr_ptr] and increment wr_ptr.
  - din_valid=0 cycles stall without effect.
  - After the DEPTH_A-th accepted sample, go to PROC next cycle; wr_ptr wraps to 0.
- PROC:
  - rd_ptr issues A[0..DEPTH_A-1] on consecutive cycles.
  - Buffer A read is synchronous, with 1-cycle latency.
  - The delay register captures each returned sample.
  - When the odd-indexed sample A[2k+1] returns, write result op(A[2k], A[2k+1]) to B[k].
  - PROC lasts exactly DEPTH_A+1 cycles; the last B write occurs in the final PROC cycle.
  - Next cycle: DONE, done=1 and busy=0.
- Arithmetic (unsigned, WIDTH bits):
  - add = A[2k]+A[2k+1], modulo 2^WIDTH.
  - sub = A[2k]−A[2k+1], modulo 2^WIDTH.
  - max/min are unsigned compare; on a tie, either operand value is returned.
- Read port:
  - rd_data = B[rd_addr] registered, 1-cycle latency, valid in every state.
  - A same-cycle B write and read of the same address returns the old contents (read-before-write).
- DONE is held indefinitely until start or reset.

Optional Feature:
- Macro PAIR_REDUCE_SAT_EN.
- Defined:
  - add saturates at 2^WIDTH−1.
  - sub clamps at 0 when A[2k+1]>A[2k].
  - max/min are unchanged.
- Undefined: add and sub wrap modulo 2^WIDTH as specified above.
- No port or timing difference either way.

Test Plan:
- Defaults, op_sel=00, start, load 1..8 back-to-back → PROC 9 cycles, done=1; reads B[0..3] = 3,7,11,15, each 1 cycle after rd_addr.
- op_sel=01, load 10,3,3,10,0,0,255,1 → B = 7,249,0,254. With PAIR_REDUCE_SAT_EN: 7,0,0,254.
- op_sel=00, load 200,100,255,255,128,127,0,0 → B = 44,254,255,0. With SAT_EN: 255,255,255,0.
- op_sel=10 then a second run with op_sel=11 from DONE, load 5,9,9,5,0,255,7,7 → max 9,9,255,7; min 5,5,0,7. Reads between runs return the previous run's values.
- din_valid toggled 1/0 every cycle during LOAD → exactly 8 samples captured, same results as back-to-back. start pulses during LOAD/PROC are ignored.
- Reset low for 1 cycle after 5 samples loaded → immediate IDLE; din_ready=0, busy=0, rd_data=0, all B reads 0. A fresh run then completes correctly.
